fifo_wr_arbiter: RTL and testbench

//  Round-robin, burst-based arbiter that shares the single write port of the asynchronous FIFO among NUM_REQ requesters.

---
 rtl/fifo_wr_arbiter.sv | 105 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 111 +++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one async-FIFO write port among NUM_REQ requesters.
// Ownership lasts up to MAX_BURST accepted beats; one IDLE bubble separates bursts.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW = $clog2(MAX_BURST + 1)
) (
  input  logic                          wclk,
  input  logic                          wrst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [OW-1:0]                 owner,
  output logic                          busy,
  input  logic                          fifo_full,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t               state, state_n;
  logic [NUM_REQ-1:0]   gnt_n;
  logic [OW-1:0]        owner_n, pick_idx;
  logic                 busy_n, pick_vld, xfer;
  logic [CW-1:0]        beat_cnt, beat_cnt_n;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] slices;

  assign slices = req_data;

  // Owner's slice is muxed unconditionally so data stays stable through stalls.
  assign fifo_data_in = slices[owner];
  assign xfer         = (state == BURST) && req[owner] && !fifo_full;
  assign fifo_w_en    = xfer;
  assign ack          = xfer ? gnt : '0;

  // Scan owner+1, owner+2, ... so the last owner gets lowest priority.
  always_comb begin
    int cand;
    cand     = 0;
    pick_vld = 1'b0;
    pick_idx = owner;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(owner) + k) % NUM_REQ;
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = OW'(cand);
      end
    end
  end

  always_comb begin
    state_n    = state;
    gnt_n      = gnt;
    owner_n    = owner;
    busy_n     = busy;
    beat_cnt_n = beat_cnt;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_n           = BURST;
          gnt_n             = '0;
          gnt_n[pick_idx]   = 1'b1;
          owner_n           = pick_idx;
          busy_n            = 1'b1;
          beat_cnt_n        = '0;
        end
      end
      BURST: begin
        if (!req[owner] || (xfer && beat_cnt == CW'(MAX_BURST - 1))) begin
          state_n = IDLE;
          gnt_n   = '0;
          busy_n  = 1'b0;
        end else if (xfer) begin
          beat_cnt_n = beat_cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      owner    <= OW'(NUM_REQ - 1);
      busy     <= 1'b0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      owner    <= owner_n;
      busy     <= busy_n;
      beat_cnt <= beat_cnt_n;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed table-driven bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4).
module tb_fifo_wr_arbiter;

  logic        wclk = 1'b0;
  logic        wrst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack, gnt;
  logic [1:0]  owner;
  logic        busy, fifo_full, fifo_w_en;
  logic [7:0]  fifo_data_in;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       full;
    logic [3:0] gnt;
    logic       busy;
    logic [1:0] owner;
    logic       w_en;
    logic [3:0] ack;
  } vec_t;

  vec_t vecs[$];

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req(req), .req_data(req_data), .ack(ack),
    .gnt(gnt), .owner(owner), .busy(busy), .fifo_full(fifo_full),
    .fifo_w_en(fifo_w_en), .fifo_data_in(fifo_data_in)
  );

  always #5 wclk = ~wclk;

  function automatic vec_t mk(logic r, logic [3:0] rq, logic f, logic [3:0] g,
                              logic b, logic [1:0] o, logic w, logic [3:0] a);
    vec_t v;
    v.rst_n = r; v.req = rq; v.full = f; v.gnt = g;
    v.busy = b;  v.owner = o; v.w_en = w; v.ack = a;
    return v;
  endfunction

  task automatic cmp(string name, logic [7:0] act, logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive inputs mid-cycle, then let combinational outputs settle.
  task automatic step(logic r, logic [3:0] rq, logic f);
    @(negedge wclk);
    wrst_n = r; req = rq; fifo_full = f;
    #1;
  endtask

  task automatic check(string tag, logic [3:0] g, logic b, logic [1:0] o,
                       logic w, logic [3:0] a);
    cmp({tag, ".gnt"},   8'(gnt),   8'(g));
    cmp({tag, ".busy"},  8'(busy),  8'(b));
    cmp({tag, ".owner"}, 8'(owner), 8'(o));
    cmp({tag, ".w_en"},  8'(fifo_w_en), 8'(w));
    cmp({tag, ".ack"},   8'(ack),   8'(a));
    if (w) cmp({tag, ".data"}, fifo_data_in, 8'hA0 + 8'(o));
  endtask

  initial begin
    wrst_n = 1'b0; req = '0; fifo_full = 1'b0;
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    repeat (2) @(posedge wclk);

    // Reset with all requesting, then full rotation 0,1,2,3,0.
    vecs.push_back(mk(0, 4'hF, 0, 4'h0, 0, 2'd3, 0, 4'h0));
    vecs.push_back(mk(1, 4'hF, 0, 4'h0, 0, 2'd3, 0, 4'h0));
    for (int o = 0; o < 4; o++) begin
      for (int b = 0; b < 4; b++)
        vecs.push_back(mk(1, 4'hF, 0, 4'(1 << o), 1, 2'(o), 1, 4'(1 << o)));
      vecs.push_back(mk(1, 4'hF, 0, 4'h0, 0, 2'(o), 0, 4'h0));
    end
    // Owner 0 again: 2 beats, 3 full cycles, 2 beats, then IDLE.
    for (int b = 0; b < 2; b++) vecs.push_back(mk(1, 4'hF, 0, 4'h1, 1, 2'd0, 1, 4'h1));
    for (int b = 0; b < 3; b++) vecs.push_back(mk(1, 4'hF, 1, 4'h1, 1, 2'd0, 0, 4'h0));
    for (int b = 0; b < 2; b++) vecs.push_back(mk(1, 4'hF, 0, 4'h1, 1, 2'd0, 1, 4'h1));
    vecs.push_back(mk(1, 4'hF, 0, 4'h0, 0, 2'd0, 0, 4'h0));

    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].req, vecs[i].full);
      check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].busy, vecs[i].owner,
            vecs[i].w_en, vecs[i].ack);
    end

    // Lone requester 2 drops after one beat, then wrap past 3 to requester 0.
    step(0, 4'b0100, 0);
    step(1, 4'b0100, 0); check("r2_idle",  4'h0, 0, 2'd3, 0, 4'h0);
    step(1, 4'b0100, 0); check("r2_beat",  4'h4, 1, 2'd2, 1, 4'h4);
    step(1, 4'b0000, 0); check("r2_drop",  4'h4, 1, 2'd2, 0, 4'h0);
    step(1, 4'b0011, 0); check("r2_rel",   4'h0, 0, 2'd2, 0, 4'h0);
    step(1, 4'b0011, 0); check("wrap_b0",  4'h1, 1, 2'd0, 1, 4'h1);
    step(1, 4'b0011, 0); check("wrap_b1",  4'h1, 1, 2'd0, 1, 4'h1);

    // Reset pulse during beat 2; regrant starts from requester 0.
    step(0, 4'b0011, 0);
    step(1, 4'b0011, 0); check("mid_rst",  4'h0, 0, 2'd3, 0, 4'h0);
    step(1, 4'b0011, 0); check("regrant",  4'h1, 1, 2'd0, 1, 4'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
